// File: rtl/apb_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_pkg
// Description : Shared types and constants for the APB wait-state completer:
//               phase encoding, register addresses and STATUS bit layout.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_slave_pkg;

    // Phase encoding for the completer FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Control register byte addresses
    localparam int unsigned WAIT_CFG_ADDR = 32'h0000_0100;
    localparam int unsigned STATUS_ADDR   = 32'h0000_0104;

    // STATUS register layout
    localparam int STATUS_CNT_LSB   = 0;
    localparam int STATUS_CNT_W     = 16;
    localparam int STATUS_PROTO_BIT = 16;

endpackage : apb_slave_pkg
`default_nettype wire

// File: rtl/apb_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_ctr
// Description : Wait-state down-counter. Loaded with the configured wait
//               count when a transfer is set up, decremented once per stalled
//               ACCESS cycle; o_done flags that no wait states remain.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               i_load     - load i_load_val (takes priority over i_dec)
//               i_load_val - wait-state count to load
//               i_dec      - decrement request (saturates at zero)
//               o_done     - counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_ctr #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_done
);

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule : apb_wait_ctr
`default_nettype wire

// File: rtl/apb_wait_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_slave
// Description : APB3 completer with a word-addressed register file, a
//               programmable number of ACCESS wait states (WAIT_CFG @0x100),
//               a STATUS register (@0x104: transfer count + sticky protocol
//               error) and PSLVERR on unmapped/misaligned/illegal accesses.
// Ports       : Pclk    - APB clock          Preset  - sync active-high reset
//               Psel    - completer select   Penable - ACCESS phase
//               Paddr   - byte address       Pwrite  - 1 = write
//               Pwdata  - write data         Prdata  - read data (on Pready)
//               Pready  - transfer complete  Pslverr - error (on Pready)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_slave
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int DEFAULT_WAIT = 2,
    parameter int WAIT_W       = 4
) (
    input  logic                  Pclk,
    input  logic                  Preset,
    input  logic                  Psel,
    input  logic                  Penable,
    input  logic [ADDR_WIDTH-1:0] Paddr,
    input  logic                  Pwrite,
    input  logic [DATA_WIDTH-1:0] Pwdata,
    output logic [DATA_WIDTH-1:0] Prdata,
    output logic                  Pready,
    output logic                  Pslverr
);

    localparam int IDX_W = $clog2(DEPTH);

    // r_state records what the previous cycle established: SETUP means a
    // setup phase was just captured, so this cycle must be the first ACCESS.
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETUP  = ST_SETUP;
    localparam logic [1:0] S_ACCESS = ST_ACCESS;

    logic [1:0]                r_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_write;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
    logic [WAIT_W-1:0]         r_wait_cfg;
    logic [STATUS_CNT_W-1:0]   r_xfer_cnt;
    logic                      r_proto_err;

    logic                      w_in_xfer;
    logic                      w_bus_access;
    logic                      w_setup;
    logic                      w_done;
    logic                      w_complete;
    logic                      w_stall;
    logic                      w_abort;
    logic                      w_oos;
    logic                      w_hit_wait;
    logic                      w_hit_status;
    logic                      w_hit_data;
    logic                      w_err;
    logic [IDX_W-1:0]          w_idx;
    logic [DATA_WIDTH-1:0]     w_rd_word;

    // ------------------------------------------------------------------
    // Phase qualification
    // ------------------------------------------------------------------
    assign w_in_xfer    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign w_bus_access = Psel && Penable;
    assign w_setup      = (r_state == S_IDLE) && Psel && !Penable;
    assign w_oos        = (r_state == S_IDLE) && Penable;
    assign w_complete   = w_in_xfer && w_bus_access && w_done;
    assign w_stall      = w_in_xfer && w_bus_access && !w_done;
    // Anything other than a held ACCESS while a transfer is open kills it
    assign w_abort      = w_in_xfer && !w_bus_access;

    apb_wait_ctr #(
        .WAIT_W     (WAIT_W)
    ) u_wait_ctr (
        .clk        (Pclk),
        .rst        (Preset),
        .i_load     (w_setup),
        .i_load_val (r_wait_cfg),
        .i_dec      (w_stall),
        .o_done     (w_done)
    );

    // ------------------------------------------------------------------
    // Address decode on the values latched at SETUP. The control
    // registers are matched first so they win over the data window.
    // ------------------------------------------------------------------
    assign w_hit_wait   = (r_addr == ADDR_WIDTH'(WAIT_CFG_ADDR));
    assign w_hit_status = (r_addr == ADDR_WIDTH'(STATUS_ADDR));
    assign w_hit_data   = (r_addr[ADDR_WIDTH-1:IDX_W+2] == '0) && (r_addr[1:0] == 2'b00);
    assign w_idx        = r_addr[IDX_W+1:2];
    assign w_err        = !(w_hit_wait || (w_hit_status && !r_write) ||
                            (!w_hit_status && w_hit_data));

    always_comb begin
        w_rd_word = '0;
        if (w_hit_wait) begin
            w_rd_word[WAIT_W-1:0] = r_wait_cfg;
        end else if (w_hit_status) begin
            w_rd_word[STATUS_CNT_LSB +: STATUS_CNT_W] = r_xfer_cnt;
            w_rd_word[STATUS_PROTO_BIT]               = r_proto_err;
        end else if (w_hit_data) begin
            w_rd_word = r_mem[w_idx];
        end
    end

    assign Pready  = w_complete;
    assign Pslverr = w_complete && w_err;
    assign Prdata  = (w_complete && !r_write && !w_err) ? w_rd_word : '0;

    // ------------------------------------------------------------------
    // FSM, register file and status
    // ------------------------------------------------------------------
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_wait_cfg  <= WAIT_W'(DEFAULT_WAIT);
            r_xfer_cnt  <= '0;
            r_proto_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_state <= S_SETUP;
                        r_addr  <= Paddr;
                        r_write <= Pwrite;
                        r_wdata <= Pwdata;
                    end else if (w_oos) begin
                        r_proto_err <= 1'b1;
                    end
                end
                S_SETUP, S_ACCESS: begin
                    if (w_abort) begin
                        r_proto_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_complete) begin
                        // Back-to-back SETUP is picked up from IDLE next cycle
                        r_state    <= S_IDLE;
                        r_xfer_cnt <= r_xfer_cnt + 1'b1;
                        if (r_write && !w_err) begin
                            if (w_hit_wait) begin
                                r_wait_cfg <= r_wdata[WAIT_W-1:0];
                            end else begin
                                r_mem[w_idx] <= r_wdata;
                            end
                        end
                    end else begin
                        r_state <= S_ACCESS;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule : apb_wait_slave
`default_nettype wire

// File: tb/tb_apb_wait_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_wait_slave
// Description : Self-checking directed bench for apb_wait_slave. Expected
//               read data / error / ACCESS length are queued when a transfer
//               is launched and checked when Pready is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_wait_slave;

    logic        clk;
    logic        Preset;
    logic        Psel;
    logic        Penable;
    logic [31:0] Paddr;
    logic        Pwrite;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb[$];

    apb_wait_slave #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .DEPTH        (16),
        .DEFAULT_WAIT (2),
        .WAIT_W       (4)
    ) dut (
        .Pclk    (clk),
        .Preset  (Preset),
        .Psel    (Psel),
        .Penable (Penable),
        .Paddr   (Paddr),
        .Pwrite  (Pwrite),
        .Pwdata  (Pwdata),
        .Prdata  (Prdata),
        .Pready  (Pready),
        .Pslverr (Pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pready only inside Psel&Penable; Prdata zero whenever not completing
    always @(negedge clk) begin
        if (!Preset) begin
            if (!(Psel && Penable)) chk("pready_outside_access", {31'b0, Pready}, 32'h0);
            if (!Pready)            chk("prdata_not_ready", Prdata, 32'h0);
        end
    end

    // Entered and left one time unit after a rising edge.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] rd, input logic er, input int nw,
                        input bit idle_after);
        exp_t e;
        exp_t g;
        int   cyc;
        bit   got;
        e.rdata = rd;
        e.err   = er;
        e.waits = nw;
        sb.push_back(e);
        Psel = 1'b1; Penable = 1'b0; Paddr = a; Pwrite = w; Pwdata = d;
        @(negedge clk);
        chk("setup_pready", {31'b0, Pready}, 32'h0);
        @(posedge clk); #1;
        Penable = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (Pready) begin
                got = 1'b1;
                g = sb.pop_front();
                chk("prdata", Prdata, g.rdata);
                chk("pslverr", {31'b0, Pslverr}, {31'b0, g.err});
                chk("access_len", cyc, g.waits + 1);
            end
            @(posedge clk); #1;
            // Bus values during ACCESS must be ignored in favour of SETUP ones
            if (!got) begin
                Paddr = 32'hFFFF_FFF0; Pwrite = ~w; Pwdata = ~d;
            end
        end
        if (!got) begin
            g = sb.pop_front();
            chk("pready_timeout", cyc, g.waits + 1);
        end
        if (idle_after) begin
            Psel = 1'b0; Penable = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Preset = 1'b1; Psel = 1'b0; Penable = 1'b0;
        Paddr = '0; Pwrite = 1'b0; Pwdata = '0;

        // 1: reset state and default wait of 2
        @(negedge clk);
        chk("reset_pready", {31'b0, Pready}, 32'h0);
        chk("reset_pslverr", {31'b0, Pslverr}, 32'h0);
        chk("reset_prdata", Prdata, 32'h0);
        @(posedge clk); #1;
        Preset = 1'b0;
        @(posedge clk); #1;
        xfer(32'h0C,  1'b0, 32'h0, 32'h0,          1'b0, 2, 1'b1);
        xfer(32'h100, 1'b0, 32'h0, 32'h2,          1'b0, 2, 1'b1);
        xfer(32'h104, 1'b0, 32'h0, 32'h2,          1'b0, 2, 1'b1);

        // 2: zero-wait operation; new WAIT_CFG applies from next transfer
        xfer(32'h100, 1'b1, 32'h0,         32'h0,          1'b0, 2, 1'b1);
        xfer(32'h08,  1'b1, 32'hDEADBEEF,  32'h0,          1'b0, 0, 1'b1);
        xfer(32'h08,  1'b0, 32'h0,         32'hDEADBEEF,   1'b0, 0, 1'b1);

        // 3: back-to-back writes with 5 wait states
        xfer(32'h100, 1'b1, 32'h5,         32'h0,          1'b0, 0, 1'b1);
        xfer(32'h10,  1'b1, 32'h11111111,  32'h0,          1'b0, 5, 1'b0);
        xfer(32'h14,  1'b1, 32'h22222222,  32'h0,          1'b0, 5, 1'b1);
        xfer(32'h104, 1'b0, 32'h0,         32'h9,          1'b0, 5, 1'b1);
        xfer(32'h10,  1'b0, 32'h0,         32'h11111111,   1'b0, 5, 1'b0);
        xfer(32'h14,  1'b0, 32'h0,         32'h22222222,   1'b0, 5, 1'b1);
        xfer(32'h100, 1'b1, 32'h1,         32'h0,          1'b0, 5, 1'b1);

        // 4: error responses leave state unchanged; WAIT_CFG upper bits
        xfer(32'h200, 1'b0, 32'h0,         32'h0,          1'b1, 1, 1'b1);
        xfer(32'h0A,  1'b1, 32'h12345678,  32'h0,          1'b1, 1, 1'b1);
        xfer(32'h08,  1'b0, 32'h0,         32'hDEADBEEF,   1'b0, 1, 1'b1);
        xfer(32'h104, 1'b1, 32'hFFFFFFFF,  32'h0,          1'b1, 1, 1'b1);
        xfer(32'h100, 1'b1, 32'hFFFFFFF1,  32'h0,          1'b0, 1, 1'b1);
        xfer(32'h100, 1'b0, 32'h0,         32'h1,          1'b0, 1, 1'b1);

        // 5: Psel dropped mid-ACCESS -> abort, no commit, no count
        Psel = 1'b1; Penable = 1'b0; Paddr = 32'h18; Pwrite = 1'b1; Pwdata = 32'h55;
        @(posedge clk); #1;
        Penable = 1'b1;
        @(negedge clk);
        chk("abort_wait_pready", {31'b0, Pready}, 32'h0);
        @(posedge clk); #1;
        Psel = 1'b0; Penable = 1'b0;
        @(negedge clk);
        chk("abort_pready", {31'b0, Pready}, 32'h0);
        @(posedge clk); #1;
        xfer(32'h104, 1'b0, 32'h0, 32'h0001_0013, 1'b0, 1, 1'b1);
        xfer(32'h18,  1'b0, 32'h0, 32'h0,         1'b0, 1, 1'b1);

        // 6: reset coinciding with the completion of a write to 0x04
        Psel = 1'b1; Penable = 1'b0; Paddr = 32'h04; Pwrite = 1'b1; Pwdata = 32'hCAFE0004;
        @(posedge clk); #1;
        Penable = 1'b1;
        @(negedge clk);
        chk("rst_wr_wait_pready", {31'b0, Pready}, 32'h0);
        @(negedge clk);
        chk("rst_wr_complete_pready", {31'b0, Pready}, 32'h1);
        Preset = 1'b1;
        @(posedge clk); #1;
        Psel = 1'b0; Penable = 1'b0;
        @(negedge clk);
        chk("post_rst_pready", {31'b0, Pready}, 32'h0);
        chk("post_rst_pslverr", {31'b0, Pslverr}, 32'h0);
        chk("post_rst_prdata", Prdata, 32'h0);
        @(posedge clk); #1;
        Preset = 1'b0;
        xfer(32'h04,  1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b1);
        xfer(32'h100, 1'b0, 32'h0, 32'h2, 1'b0, 2, 1'b1);
        xfer(32'h104, 1'b0, 32'h0, 32'h2, 1'b0, 2, 1'b1);

        // Out-of-sequence Penable in IDLE: no transfer, sticky PROTO_ERR
        Psel = 1'b1; Penable = 1'b1; Paddr = 32'h0; Pwrite = 1'b1; Pwdata = 32'hFFFF;
        @(negedge clk);
        chk("oos_pready", {31'b0, Pready}, 32'h0);
        @(posedge clk); #1;
        Psel = 1'b0; Penable = 1'b0;
        @(posedge clk); #1;
        xfer(32'h104, 1'b0, 32'h0, 32'h0001_0003, 1'b0, 2, 1'b1);
        xfer(32'h00,  1'b0, 32'h0, 32'h0,         1'b0, 2, 1'b1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_apb_wait_slave
`default_nettype wire
